// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared sizing, FSM state and lane-marker types for the skew feeder
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 32
`endif

package npu_pkg;

  localparam int SA_DATA_W = 8;
  localparam int SA_N      = `BUFFER_WIDTH / SA_DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

  typedef struct packed {
    logic valid;
    logic in_first;
    logic in_last;
    logic w_first;
    logic w_last;
  } lane_mark_t;

endpackage

// File: rtl/skew_lane.sv
// rtl/skew_lane.sv - one lane's flushable delay line; DEPTH=0 is a wire
module skew_lane #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, flush};
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] pipe [DEPTH];

      always_ff @(posedge clk) begin
        if (flush) begin
          for (int k = 0; k < DEPTH; k++) pipe[k] <= '0;
        end else begin
          pipe[0] <= d;
          for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
        end
      end

      assign q = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - diagonal skew of input/weight words into the systolic array
// Optional beat_count output enabled by SKEW_FEEDER_STATS_EN.
module systolic_skew_feeder
  import npu_pkg::*;
#(
  parameter int N      = SA_N,
  parameter int DATA_W = SA_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                compute_enable,
  input  logic                acc_clear,
  input  logic                sa_input_first,
  input  logic                sa_input_last,
  input  logic                sa_weight_first,
  input  logic                sa_weight_last,
  input  logic [N*DATA_W-1:0] ub_rdata,
  input  logic [N*DATA_W-1:0] ub_w_rdata,
  output logic [N*DATA_W-1:0] sa_in_data,
  output logic [N*DATA_W-1:0] sa_w_data,
  output logic [N-1:0]        sa_valid,
  output logic [N-1:0]        sa_in_first,
  output logic [N-1:0]        sa_in_last,
  output logic [N-1:0]        sa_w_first,
  output logic [N-1:0]        sa_w_last,
  output logic                busy,
  output logic                protocol_err,
`ifdef SKEW_FEEDER_STATS_EN
  output logic [15:0]         beat_count,
`endif
  output logic                all_done
);

  localparam int MW = $bits(lane_mark_t);
  localparam int LW = 2 * DATA_W + MW;

  // rst_n is active-high; reset and acc_clear share the same pipeline flush
  logic flush;
  assign flush = rst_n | acc_clear;

  lane_mark_t          cap_mark;
  lane_mark_t          s0_mark;
  logic [N*DATA_W-1:0] s0_in;
  logic [N*DATA_W-1:0] s0_w;

  always_ff @(posedge clk) begin
    if (flush) begin
      cap_mark <= '0;
    end else begin
      cap_mark.valid    <= compute_enable;
      cap_mark.in_first <= compute_enable & sa_input_first;
      cap_mark.in_last  <= compute_enable & sa_input_last;
      cap_mark.w_first  <= compute_enable & sa_weight_first;
      cap_mark.w_last   <= compute_enable & sa_weight_last;
    end
  end

  // Data is zeroed at stage 0 so idle slots propagate as zero through every lane
  always_ff @(posedge clk) begin
    if (flush) begin
      s0_mark <= '0;
      s0_in   <= '0;
      s0_w    <= '0;
    end else begin
      s0_mark <= cap_mark;
      s0_in   <= cap_mark.valid ? ub_rdata   : '0;
      s0_w    <= cap_mark.valid ? ub_w_rdata : '0;
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [LW-1:0] ld;
      logic [LW-1:0] lq;
      lane_mark_t    m;

      assign ld = {s0_in[i*DATA_W +: DATA_W], s0_w[i*DATA_W +: DATA_W], s0_mark};

      skew_lane #(.DEPTH(i), .WIDTH(LW)) u_lane (
        .clk   (clk),
        .flush (flush),
        .d     (ld),
        .q     (lq)
      );

      assign m                            = lq[MW-1:0];
      assign sa_in_data[i*DATA_W +: DATA_W] = lq[LW-1 -: DATA_W];
      assign sa_w_data[i*DATA_W +: DATA_W]  = lq[LW-1-DATA_W -: DATA_W];
      assign sa_valid[i]                  = m.valid;
      assign sa_in_first[i]               = m.in_first;
      assign sa_in_last[i]                = m.in_last;
      assign sa_w_first[i]                = m.w_first;
      assign sa_w_last[i]                 = m.w_last;
    end
  endgenerate

  feeder_state_t state, state_nx;
  logic          err_set;

  always_ff @(posedge clk) begin
    if (flush) state <= IDLE;
    else       state <= state_nx;
  end

  // The FSM judges each beat as it is captured; DONE accepts a new tile like IDLE
  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (compute_enable) begin
          if (!sa_input_first)    err_set  = 1'b1;
          else if (sa_input_last) state_nx = DRAIN;
          else                    state_nx = STREAM;
        end
      end
      STREAM: begin
        if (compute_enable) begin
          if (sa_input_first) err_set  = 1'b1;
          if (sa_input_last)  state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (compute_enable) err_set = 1'b1;
        if (sa_valid[N-1] && sa_in_last[N-1]) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    all_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst_n)                     protocol_err <= 1'b0;
    else if (!acc_clear && err_set) protocol_err <= 1'b1;
  end

`ifdef SKEW_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (flush)                                        beat_count <= '0;
    else if (sa_valid[N-1] && beat_count != 16'hFFFF) beat_count <= beat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - table-driven and scoreboard bench for systolic_skew_feeder
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, compute_enable, acc_clear, sif, sil, swf, swl;
  logic [N*DW-1:0] ub_rdata, ub_w_rdata, sa_in_data, sa_w_data;
  logic [N-1:0]  sa_valid, sa_in_first, sa_in_last, sa_w_first, sa_w_last;
  logic          busy, protocol_err, all_done;
`ifdef SKEW_FEEDER_STATS_EN
  logic [15:0]   beat_count;
`endif

  systolic_skew_feeder #(.N(N), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .compute_enable  (compute_enable),
    .acc_clear       (acc_clear),
    .sa_input_first  (sif),
    .sa_input_last   (sil),
    .sa_weight_first (swf),
    .sa_weight_last  (swl),
    .ub_rdata        (ub_rdata),
    .ub_w_rdata      (ub_w_rdata),
    .sa_in_data      (sa_in_data),
    .sa_w_data       (sa_w_data),
    .sa_valid        (sa_valid),
    .sa_in_first     (sa_in_first),
    .sa_in_last      (sa_in_last),
    .sa_w_first      (sa_w_first),
    .sa_w_last       (sa_w_last),
    .busy            (busy),
    .protocol_err    (protocol_err),
`ifdef SKEW_FEEDER_STATS_EN
    .beat_count      (beat_count),
`endif
    .all_done        (all_done)
  );

  typedef struct {
    int         due;
    int         lane;
    logic [7:0] d;
    logic [7:0] w;
    logic [3:0] mk;
  } exp_t;

  typedef struct {
    logic [31:0]     din;
    logic [31:0]     w;
    logic [3:0]      mk;
    logic [3:0][7:0] ein;
    logic [3:0][7:0] ew;
  } vec_t;

  exp_t        sbq[$];
  int          done_q[$];
  vec_t        tv[4];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          mon_on = 1'b0;
  bit          nxt_set = 1'b0;
  logic [31:0] nxt_in, nxt_w;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (nxt_set) begin
      ub_rdata   = nxt_in;
      ub_w_rdata = nxt_w;
    end else begin
      ub_rdata   = $urandom;
      ub_w_rdata = $urandom;
    end
    nxt_set = 1'b0;
    compute_enable = 1'b0; acc_clear = 1'b0; rst_n = 1'b0;
    sif = 1'b0; sil = 1'b0; swf = 1'b0; swl = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic beat(input logic [31:0] din, input logic [31:0] w, input logic [3:0] mk);
    compute_enable = 1'b1;
    {sif, sil, swf, swl} = mk;
    nxt_in = din; nxt_w = w; nxt_set = 1'b1;
  endtask

  task automatic expect_lane(input int t, input int lane, input logic [7:0] d,
                             input logic [7:0] w, input logic [3:0] mk);
    exp_t e;
    e.due = t + 2 + lane; e.lane = lane; e.d = d; e.w = w; e.mk = mk;
    sbq.push_back(e);
  endtask

  task automatic expect_word(input int t, input logic [31:0] din, input logic [31:0] w,
                             input logic [3:0] mk);
    for (int i = 0; i < N; i++)
      expect_lane(t, i, 8'((din >> (8*i)) & 32'hff), 8'((w >> (8*i)) & 32'hff), mk);
  endtask

  task automatic flush_model(input int c);
    for (int k = sbq.size() - 1; k >= 0; k--)  if (sbq[k].due > c) sbq.delete(k);
    for (int k = done_q.size() - 1; k >= 0; k--) if (done_q[k] > c) done_q.delete(k);
  endtask

  always @(negedge clk) begin : mon
    logic [31:0] ei, ew;
    logic [3:0]  ev, ef, el, ewf, ewl;
    logic        ed;
    int          ln;
    if (mon_on) begin
      ei = '0; ew = '0; ev = '0; ef = '0; el = '0; ewf = '0; ewl = '0; ed = 1'b0;
      for (int k = sbq.size() - 1; k >= 0; k--) begin
        if (sbq[k].due == cyc) begin
          ln = sbq[k].lane;
          ei[ln*8 +: 8] = sbq[k].d;
          ew[ln*8 +: 8] = sbq[k].w;
          ev[ln] = 1'b1;
          {ef[ln], el[ln], ewf[ln], ewl[ln]} = sbq[k].mk;
          sbq.delete(k);
        end
      end
      for (int k = done_q.size() - 1; k >= 0; k--)
        if (done_q[k] == cyc) begin ed = 1'b1; done_q.delete(k); end
      chk("sa_valid", 64'(sa_valid), 64'(ev));
      chk("sa_in_data", 64'(sa_in_data), 64'(ei));
      chk("sa_w_data", 64'(sa_w_data), 64'(ew));
      chk("sa_in_first", 64'(sa_in_first), 64'(ef));
      chk("sa_in_last", 64'(sa_in_last), 64'(el));
      chk("sa_w_first", 64'(sa_w_first), 64'(ewf));
      chk("sa_w_last", 64'(sa_w_last), 64'(ewl));
      chk("all_done", 64'(all_done), 64'(ed));
    end
  end

  initial begin
    int t;
    tv[0] = '{32'h44332211, 32'hddccbbaa, 4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, {8'hdd, 8'hcc, 8'hbb, 8'haa}};
    tv[1] = '{32'h00ff00ff, 32'h0f0f0f0f, 4'b1100, {8'h00, 8'hff, 8'h00, 8'hff}, {8'h0f, 8'h0f, 8'h0f, 8'h0f}};
    tv[2] = '{32'h80017f02, 32'h12345678, 4'b1110, {8'h80, 8'h01, 8'h7f, 8'h02}, {8'h12, 8'h34, 8'h56, 8'h78}};
    tv[3] = '{32'hffffffff, 32'h00000000, 4'b1101, {8'hff, 8'hff, 8'hff, 8'hff}, {8'h00, 8'h00, 8'h00, 8'h00}};

    compute_enable = 1'b0; acc_clear = 1'b0; sif = 1'b0; sil = 1'b0; swf = 1'b0; swl = 1'b0;
    ub_rdata = '0; ub_w_rdata = '0;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(protocol_err), 64'd0);
    tick();

    // single-beat tiles from the vector table
    for (int k = 0; k < 4; k++) begin
      t = cyc;
      beat(tv[k].din, tv[k].w, tv[k].mk);
      for (int i = 0; i < N; i++) expect_lane(t, i, tv[k].ein[i], tv[k].ew[i], tv[k].mk);
      done_q.push_back(t + N + 2);
      tick();
      @(negedge clk);
      chk("busy_single", 64'(busy), 64'd1);
      ticks(8);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_err", 64'(protocol_err), 64'd0);
    end

    // three-beat tile
    t = cyc;
    beat(32'ha1a2a3a4, 32'h01020304, 4'b1010); expect_word(t, 32'ha1a2a3a4, 32'h01020304, 4'b1010);
    tick();
    beat(32'h5566aa77, 32'h11111111, 4'b0000); expect_word(t + 1, 32'h5566aa77, 32'h11111111, 4'b0000);
    @(negedge clk);
    chk("tile_busy", 64'(busy), 64'd1);
    tick();
    beat(32'hdeadbeef, 32'hcafef00d, 4'b0101); expect_word(t + 2, 32'hdeadbeef, 32'hcafef00d, 4'b0101);
    done_q.push_back(t + 2 + N + 2);
    ticks(10);
    chk("tile_idle", 64'(busy), 64'd0);

    // new single-beat tile issued in the DONE cycle of the previous one
    t = cyc;
    beat(32'h01234567, 32'h89abcdef, 4'b1100); expect_word(t, 32'h01234567, 32'h89abcdef, 4'b1100);
    done_q.push_back(t + 6);
    ticks(6);
    beat(32'h76543210, 32'hfedcba98, 4'b1100); expect_word(t + 6, 32'h76543210, 32'hfedcba98, 4'b1100);
    done_q.push_back(t + 12);
    ticks(10);
    chk("b2b_err", 64'(protocol_err), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd0);

    // acc_clear in the middle of a draining beat
    t = cyc;
    beat(32'h44332211, 32'h0, 4'b1100); expect_word(t, 32'h44332211, 32'h0, 4'b1100);
    done_q.push_back(t + 6);
    ticks(3);
    acc_clear = 1'b1;
    flush_model(cyc);
    tick();
    @(negedge clk);
    chk("clr_busy", 64'(busy), 64'd0);
    ticks(6);

    // acc_clear and compute_enable together: beat is dropped
    acc_clear = 1'b1;
    beat(32'h99999999, 32'h99999999, 4'b1100);
    tick();
    @(negedge clk);
    chk("drop_busy", 64'(busy), 64'd0);
    ticks(6);

    // beat without input_first while idle
    t = cyc;
    beat(32'h0badf00d, 32'h12121212, 4'b0100); expect_word(t, 32'h0badf00d, 32'h12121212, 4'b0100);
    ticks(8);
    chk("err_set", 64'(protocol_err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    acc_clear = 1'b1;
    tick();
    ticks(2);
    chk("err_sticky", 64'(protocol_err), 64'd1);

    // reset in the middle of a stream
    t = cyc;
    beat(32'h13572468, 32'h24681357, 4'b1000); expect_word(t, 32'h13572468, 32'h24681357, 4'b1000);
    ticks(3);
    rst_n = 1'b1;
    flush_model(cyc);
    tick();
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_err", 64'(protocol_err), 64'd0);
    ticks(6);

`ifdef SKEW_FEEDER_STATS_EN
    t = cyc;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] mk;
      mk = {k == 0, k == 4, 2'b00};
      beat(32'h10101010 * (k + 1), 32'h01010101 * (k + 1), mk);
      expect_word(t + k, 32'h10101010 * (k + 1), 32'h01010101 * (k + 1), mk);
      tick();
    end
    done_q.push_back(t + 4 + N + 2);
    ticks(8);
    chk("beat_count", 64'(beat_count), 64'd5);
    acc_clear = 1'b1;
    tick();
    @(negedge clk);
    chk("beat_count_clr", 64'(beat_count), 64'd0);
`endif

    ticks(4);
    chk("sb_empty", 64'(sbq.size() + done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Sits between the unified buffer/control path and the systolic array. It captures one row-wide input word and one weight word per compute beat and applies the diagonal skew: lane i is delayed by i cycles. The first/last sequencer markers travel with the data, and idle lanes are zero-padded. When the last input beat has exited the deepest lane, it returns a one-cycle all_done pulse to the control unit.

Parameters:
N, 4, array dimension; number of lanes and number of skew stages.
DATA_W, 8, element width; lane k of a buffer word occupies bits [k*DATA_W +: DATA_W].

Ports:
clk  in  1  single clock.
rst_n  in  1  reset; synchronous, active-high (1 = reset), despite the legacy name.
compute_enable  in  1  beat issued this cycle; buffer data for the beat arrives next cycle.
acc_clear  in  1  synchronous flush of all skew pipelines.
sa_input_first / sa_input_last  in  1 each  input tile markers, aligned with compute_enable.
sa_weight_first / sa_weight_last  in  1 each  weight tile markers, aligned with compute_enable.
ub_rdata  in  N*DATA_W  input word, valid one cycle after the beat.
ub_w_rdata  in  N*DATA_W  weight word from the weight read port, same timing as ub_rdata.
sa_in_data  out  N*DATA_W  skewed input lanes.
sa_w_data  out  N*DATA_W  skewed weight lanes.
sa_valid  out  N  per-lane valid.
sa_in_first / sa_in_last / sa_w_first / sa_w_last  out  N each  per-lane markers.
busy  out  1  FSM is not in IDLE.
protocol_err  out  1  sticky error flag.
all_done  out  1  one-cycle pulse to the control unit's all_done_in.

Behaviour:
Reset state:
- Every output is 0; all pipeline valid bits and markers are 0; FSM is in IDLE.
- Reset mid-stream discards all in-flight beats and raises no all_done.

Capture stage (cycle t+1 for a beat issued at t):
- Register the delayed compute_enable and the four markers, aligned with ub_rdata and ub_w_rdata.

Skew stage:
- Lane i passes through i extra register stages.
- Lane i is valid at cycle t+2+i and carries element i of the beat's input and weight words plus the markers.
- Any lane that is not valid drives zero data and zero markers.

acc_clear:
- Takes effect at the clock edge: clears every valid bit and marker in both the capture and skew stages and returns the FSM to IDLE.
- No all_done is produced.
- When acc_clear and compute_enable are high in the same cycle, acc_clear wins and the beat is dropped.

FSM states:
- IDLE:
  - A captured beat with input_first goes to STREAM.
  - A captured beat with both input_first and input_last (single-beat tile) goes straight to DRAIN.
  - A captured beat without input_first is still skewed out, but sets protocol_err.
- STREAM:
  - A captured beat with input_last goes to DRAIN.
  - A captured beat with input_first sets protocol_err; it is treated as a continuation and the state is unchanged.
- DRAIN:
  - When lane N-1 outputs a valid beat with input_last, go to DONE.
  - Beats captured while in DRAIN set protocol_err and are still skewed out.
- DONE:
  - all_done = 1 for exactly one cycle, then IDLE.
  - A captured beat with input_first in the same cycle is accepted, as though the FSM were already in IDLE.

Latency and flags:
- all_done fires N+2 cycles after the compute_enable of the last beat.
- busy = (state != IDLE).
- protocol_err is cleared only by reset.
- Weight markers are pipelined only and do not affect the FSM.

Optional Feature:
Macro SKEW_FEEDER_STATS_EN.
- Defined: adds output beat_count [15:0], which counts beats exiting lane N-1.
  - Saturates at 0xFFFF.
  - Cleared by reset and by acc_clear.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
Shared package (npu_pkg):
- feeder_state_t enum {IDLE, STREAM, DRAIN, DONE}.
- SA_N and SA_DATA_W constants, tied to `BUFFER_WIDTH / element width.
- A lane-marker struct {valid, in_first, in_last, w_first, w_last}.

Sub-module skew_lane:
- One lane's delay line; parameters DEPTH and WIDTH, with a flush input.
- Instantiated N times by a generate loop; each instance carries data, weight and the marker struct.
- DEPTH=0 is a pass-through.

Test Plan:
1. N=4, single beat at t=10 (first and last), ub_rdata=0x44332211 -> sa_valid[0]@12 data 0x11; [1]@13 0x22; [2]@14 0x33; [3]@15 0x44; all_done@16; protocol_err=0.
2. Tile of 3 consecutive beats at t=20..22 (first on beat 0, last on beat 2) -> busy=1 from 21; lane 3 valid 25..27; all_done@28; idle lanes read 0.
3. acc_clear at t=13 during the scenario-1 stream -> all sa_valid=0 from 14; no all_done; busy=0.
4. Beat without input_first while IDLE -> data skewed out normally; protocol_err=1 and stays set until reset.
5. rst_n=1 at t=13 mid-stream -> all outputs 0 from the next edge; no all_done.
6. SKEW_FEEDER_STATS_EN defined, 5 beats streamed -> beat_count=5; after acc_clear beat_count=0.
